usb_rx_decoder: RTL and testbench

//  USB full-speed receive path; mirror of usb_tx. Decodes D+/D- line into packets: sync, NRZI, bit unstuff, SYNC/PID check, byte assembly, EOP.

---
 rtl/usb_pkg.sv | 55 +++++
 rtl/usb_rx_decoder_if.sv | 40 ++++
 rtl/usb_rx_decoder_bit_recovery.sv | 76 +++++++
 rtl/usb_rx_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// USB shared definitions: PID nibbles, packet codes, SYNC pattern.
// Used by both the receive decoder and the transmitter.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    RX_NONE  = 3'd0,
    RX_OUT   = 3'd1,
    RX_IN    = 3'd2,
    RX_DATA0 = 3'd3,
    RX_DATA1 = 3'd4,
    RX_ACK   = 3'd5,
    RX_NAK   = 3'd6,
    RX_STALL = 3'd7
  } rx_packet_t;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_SYNC,
    S_PID,
    S_TOKEN,
    S_DATA,
    S_EOP,
    S_ERR_WAIT
  } rx_state_t;

  function automatic rx_packet_t pid_decode(
    input logic [3:0] p
  );
    rx_packet_t r;
    r = RX_NONE;
    unique case (p)
      PID_OUT:   r = RX_OUT;
      PID_IN:    r = RX_IN;
      PID_DATA0: r = RX_DATA0;
      PID_DATA1: r = RX_DATA1;
      PID_ACK:   r = RX_ACK;
      PID_NAK:   r = RX_NAK;
      PID_STALL: r = RX_STALL;
      default:   r = RX_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usb_rx_decoder_if.sv
// Line inputs and status/data outputs of the USB receive decoder.
// master = decoder side, slave = line driver / consumer side.
interface usb_rx_decoder_if;
  import usb_pkg::*;

  logic       dp_in;
  logic       dm_in;
  rx_packet_t rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       flush;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;

  modport master (
    input  dp_in,
    input  dm_in,
    output rx_packet,
    output rx_data_ready,
    output rx_transfer_active,
    output rx_error,
    output flush,
    output store_rx_packet_data,
    output rx_packet_data
  );

  modport slave (
    output dp_in,
    output dm_in,
    input  rx_packet,
    input  rx_data_ready,
    input  rx_transfer_active,
    input  rx_error,
    input  flush,
    input  store_rx_packet_data,
    input  rx_packet_data
  );

endinterface

// File: rtl/usb_rx_decoder_bit_recovery.sv
// Line synchroniser, bit clock recovery, NRZI decode and bit unstuffing.
// tick marks each mid-bit sample; bit_valid only for non-stuffed data bits.
module usb_rx_bit_recovery #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dp_in,
  input  logic dm_in,
  input  logic run,
  output logic tick,
  output logic bit_valid,
  output logic bit_val,
  output logic se0,
  output logic j_state,
  output logic stuff_err,
  output logic stuff_pend
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    dp_sync;
  logic [1:0]    dm_sync;
  logic          dp_q;
  logic [CW-1:0] cnt;
  logic          prev;
  logic [2:0]    ones;
  logic          dp;
  logic          dm;
  logic          dp_edge;
  logic          nrzi;
  logic          data_tick;

  assign dp        = dp_sync[1];
  assign dm        = dm_sync[1];
  assign se0       = !dp && !dm;
  assign j_state   = dp && !dm;
  assign dp_edge   = dp ^ dp_q;
  assign tick      = (cnt == HALF);
  assign nrzi      = (dp == prev);
  assign bit_val   = nrzi;
  assign stuff_pend = (ones == 3'd6);
  assign data_tick = run && tick && !se0;
  assign bit_valid = data_tick && !stuff_pend;
  assign stuff_err = data_tick && stuff_pend && nrzi;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync <= '0;
      dm_sync <= '0;
      dp_q    <= 1'b0;
      cnt     <= '0;
      prev    <= 1'b1;
      ones    <= '0;
    end else begin
      dp_sync <= {dp_sync[0], dp_in};
      dm_sync <= {dm_sync[0], dm_in};
      dp_q    <= dp;
      // every D+ transition re-centres the sample point
      cnt <= (dp_edge || cnt == LAST) ? '0 : cnt + 1'b1;
      if (!run) begin
        prev <= 1'b1;
        ones <= '0;
      end else if (data_tick) begin
        prev <= dp;
        if (stuff_pend)
          ones <= nrzi ? ones : 3'd0;
        else
          ones <= nrzi ? ones + 3'd1 : 3'd0;
      end
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive decoder: packet FSM, byte assembly,
// two-byte delay line that keeps the CRC16 out of the data buffer.
module usb_rx_decoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_PAYLOAD  = 64
) (
  input logic             clk,
  input logic             rst,
  usb_rx_decoder_if.master bus
);

  localparam int BW = $clog2(MAX_PAYLOAD + 3);
  localparam logic [BW-1:0] TWO      = BW'(2);
  localparam logic [BW-1:0] BYTE_MAX = BW'(MAX_PAYLOAD + 2);

  rx_state_t  state, state_n;
  rx_packet_t pid_q, pid_code;

  logic tick, bit_valid, bit_val;
  logic se0, j_state, stuff_err, stuff_pend;
  logic run, se0_tick, eop_ok, byte_done, pid_ok;
  logic [6:0]    sr;
  logic [7:0]    byte_val;
  logic [2:0]    bitcnt;
  logic [BW-1:0] bytecnt;
  logic [7:0]    d0, d1;
  logic [2:0]    idle_cnt;
  logic          se0_seen, ready_d;
  logic err_ev, sync_ok, pid_load, flush_ev;
  logic byte_inc, store_ev, eop_good, se0_set;

  usb_rx_bit_recovery #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bits (
    .clk       (clk),
    .rst       (rst),
    .dp_in     (bus.dp_in),
    .dm_in     (bus.dm_in),
    .run       (run),
    .tick      (tick),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .se0       (se0),
    .j_state   (j_state),
    .stuff_err (stuff_err),
    .stuff_pend(stuff_pend)
  );

  assign run = state inside {S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOP};
  assign se0_tick  = tick && se0;
  assign eop_ok    = (bitcnt == 3'd0) && !stuff_pend;
  assign byte_val  = {bit_val, sr};
  assign byte_done = bit_valid && (bitcnt == 3'd7);
  assign pid_code  = pid_decode(byte_val[3:0]);
  assign pid_ok    = (byte_val[7:4] == ~byte_val[3:0])
                  && (pid_code != RX_NONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    err_ev   = 1'b0;
    sync_ok  = 1'b0;
    pid_load = 1'b0;
    flush_ev = 1'b0;
    byte_inc = 1'b0;
    store_ev = 1'b0;
    eop_good = 1'b0;
    se0_set  = 1'b0;
    unique case (state)
      S_WAIT_IDLE:
        if (tick && j_state && idle_cnt == 3'd7)
          state_n = S_IDLE;
      S_IDLE:
        if (!j_state && !se0) state_n = S_SYNC;
      S_SYNC:
        if (stuff_err || se0_tick) err_ev = 1'b1;
        else if (byte_done) begin
          if (byte_val == SYNC_BYTE) begin
            sync_ok = 1'b1;
            state_n = S_PID;
          end else err_ev = 1'b1;
        end
      S_PID:
        if (stuff_err || se0_tick) err_ev = 1'b1;
        else if (byte_done) begin
          if (!pid_ok) err_ev = 1'b1;
          else begin
            pid_load = 1'b1;
            case (pid_code)
              RX_OUT, RX_IN: state_n = S_TOKEN;
              RX_DATA0, RX_DATA1: begin
                flush_ev = 1'b1;
                state_n  = S_DATA;
              end
              default: state_n = S_EOP;
            endcase
          end
        end
      S_TOKEN:
        if (stuff_err) err_ev = 1'b1;
        else if (se0_tick) begin
          if (eop_ok && bytecnt == TWO) begin
            se0_set = 1'b1;
            state_n = S_EOP;
          end else err_ev = 1'b1;
        end else if (byte_done) begin
          if (bytecnt == TWO) err_ev = 1'b1;
          else byte_inc = 1'b1;
        end
      S_DATA:
        if (stuff_err) err_ev = 1'b1;
        else if (se0_tick) begin
          if (eop_ok && bytecnt >= TWO) begin
            se0_set = 1'b1;
            state_n = S_EOP;
          end else err_ev = 1'b1;
        end else if (byte_done) begin
          if (bytecnt == BYTE_MAX) err_ev = 1'b1;
          else begin
            byte_inc = 1'b1;
            store_ev = (bytecnt >= TWO);
          end
        end
      S_EOP:
        if (stuff_err) err_ev = 1'b1;
        else if (se0_tick) begin
          if (se0_seen || eop_ok) se0_set = 1'b1;
          else err_ev = 1'b1;
        end else if (tick) begin
          if (se0_seen && j_state) begin
            eop_good = 1'b1;
            state_n  = S_IDLE;
          end else err_ev = 1'b1;
        end
      S_ERR_WAIT:
        if (se0_tick) se0_set = 1'b1;
        else if (tick && j_state && se0_seen)
          state_n = S_IDLE;
    endcase
    if (err_ev) state_n = S_ERR_WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_packet            <= RX_NONE;
      bus.rx_data_ready        <= 1'b0;
      bus.rx_transfer_active   <= 1'b0;
      bus.rx_error             <= 1'b0;
      bus.flush                <= 1'b0;
      bus.store_rx_packet_data <= 1'b0;
      bus.rx_packet_data       <= '0;
      pid_q    <= RX_NONE;
      ready_d  <= 1'b0;
      sr       <= '0;
      bitcnt   <= '0;
      bytecnt  <= '0;
      d0       <= '0;
      d1       <= '0;
      idle_cnt <= '0;
      se0_seen <= 1'b0;
    end else begin
      bus.flush                <= flush_ev;
      bus.store_rx_packet_data <= store_ev;
      if (store_ev) bus.rx_packet_data <= d0;
      ready_d <= eop_good
              && (pid_q == RX_DATA0 || pid_q == RX_DATA1);
      bus.rx_data_ready <= ready_d;
      if (sync_ok) begin
        bus.rx_transfer_active <= 1'b1;
        bus.rx_error           <= 1'b0;
      end
      if (err_ev) begin
        bus.rx_transfer_active <= 1'b0;
        bus.rx_error           <= 1'b1;
      end
      if (eop_good) begin
        bus.rx_transfer_active <= 1'b0;
        bus.rx_packet          <= pid_q;
      end
      if (!run)          bitcnt <= '0;
      else if (bit_valid) bitcnt <= bitcnt + 3'd1;
      if (bit_valid) sr <= byte_val[7:1];
      if (state != S_TOKEN && state != S_DATA)
        bytecnt <= '0;
      else if (byte_inc)
        bytecnt <= bytecnt + 1'b1;
      // newest byte enters d1; d0 is released only once two newer exist
      if (byte_inc) begin
        d0 <= d1;
        d1 <= byte_val;
      end
      if (pid_load) pid_q <= pid_code;
      se0_seen <= (state_n == state) ? (se0_seen | se0_set)
                                     : se0_set;
      if (state != S_WAIT_IDLE) idle_cnt <= '0;
      else if (tick) idle_cnt <= j_state ? idle_cnt + 3'd1 : 3'd0;
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: NRZI/bit-stuffing line driver,
// expected-event queue checked by an independent output monitor.
module tb_usb_rx_decoder;
  import usb_pkg::*;

  localparam int CPB = 8;
  localparam logic [1:0] K_FLUSH = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_READY = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic lvl = 1'b1;
  int   ones = 0;

  usb_rx_decoder_if bus();

  usb_rx_decoder #(
    .CLKS_PER_BIT(CPB),
    .MAX_PAYLOAD (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic chk_ev(input logic [1:0] k, input logic [7:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d val %02h, expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL event: got kind %0d val %02h, expected kind %0d val %02h",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.flush) chk_ev(K_FLUSH, 8'h00);
      if (bus.store_rx_packet_data)
        chk_ev(K_STORE, bus.rx_packet_data);
      if (bus.rx_data_ready)
        chk_ev(K_READY, {5'd0, bus.rx_packet});
    end
  end

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic line(input logic dp, input logic dm);
    bus.dp_in = dp;
    bus.dm_in = dm;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit stuff);
    if (!b) lvl = ~lvl;
    line(lvl, !lvl);
    if (b) ones++;
    else ones = 0;
    if (stuff && ones == 6) begin
      lvl = ~lvl;
      line(lvl, !lvl);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b1);
  endtask

  task automatic send_sync();
    lvl  = 1'b1;
    ones = 0;
    send_byte(SYNC_BYTE);
  endtask

  task automatic send_eop(input int idle_bits);
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    lvl  = 1'b1;
    ones = 0;
    repeat (idle_bits) line(1'b1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] part;
    bus.dp_in = 1'b1;
    bus.dm_in = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rx_packet", {5'd0, bus.rx_packet}, 8'd0);
    check("reset active", {7'd0, bus.rx_transfer_active}, 8'd0);
    check("reset error", {7'd0, bus.rx_error}, 8'd0);
    check("reset store", {7'd0, bus.store_rx_packet_data}, 8'd0);
    rst = 1'b0;
    repeat (12) line(1'b1, 1'b0);

    // ACK handshake
    send_sync();
    send_byte(8'hD2);
    check("ack active mid", {7'd0, bus.rx_transfer_active}, 8'd1);
    send_eop(4);
    check("ack rx_packet", {5'd0, bus.rx_packet}, 8'd5);
    check("ack active end", {7'd0, bus.rx_transfer_active}, 8'd0);
    check("ack error", {7'd0, bus.rx_error}, 8'd0);

    // DATA0 with three payload bytes and two CRC bytes
    expect_ev(K_FLUSH, 8'h00);
    expect_ev(K_STORE, 8'h01);
    expect_ev(K_STORE, 8'h02);
    expect_ev(K_STORE, 8'h03);
    expect_ev(K_READY, 8'd3);
    send_sync();
    send_byte(8'hC3);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h5A);
    send_byte(8'h3C);
    send_eop(4);
    check("data0 rx_packet", {5'd0, bus.rx_packet}, 8'd3);
    check("data0 error", {7'd0, bus.rx_error}, 8'd0);

    // DATA1 payload 0xFF carries a stuffed bit
    expect_ev(K_FLUSH, 8'h00);
    expect_ev(K_STORE, 8'hFF);
    expect_ev(K_READY, 8'd4);
    send_sync();
    send_byte(8'h4B);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_eop(4);
    check("data1 ff rx_packet", {5'd0, bus.rx_packet}, 8'd4);

    // seven raw ones: stuffing violation
    expect_ev(K_FLUSH, 8'h00);
    send_sync();
    send_byte(8'h4B);
    repeat (7) send_bit(1'b1, 1'b0);
    send_eop(4);
    check("stuff error flag", {7'd0, bus.rx_error}, 8'd1);
    check("stuff rx_packet", {5'd0, bus.rx_packet}, 8'd4);
    check("stuff active", {7'd0, bus.rx_transfer_active}, 8'd0);

    // PID nibble mismatch
    send_sync();
    send_byte(8'hD3);
    send_eop(4);
    check("badpid error", {7'd0, bus.rx_error}, 8'd1);
    check("badpid rx_packet", {5'd0, bus.rx_packet}, 8'd4);

    send_sync();
    send_byte(8'hD2);
    send_eop(4);
    check("ack2 error", {7'd0, bus.rx_error}, 8'd0);
    check("ack2 rx_packet", {5'd0, bus.rx_packet}, 8'd5);

    // SE0 after four bits of a payload byte
    expect_ev(K_FLUSH, 8'h00);
    send_sync();
    send_byte(8'hC3);
    part = 8'h05;
    for (int i = 0; i < 4; i++) send_bit(part[i], 1'b1);
    send_eop(4);
    check("se0 mid error", {7'd0, bus.rx_error}, 8'd1);
    check("se0 mid rx_packet", {5'd0, bus.rx_packet}, 8'd5);

    // OUT token
    send_sync();
    send_byte(8'hE1);
    send_byte(8'h01);
    send_byte(8'hE8);
    send_eop(4);
    check("out rx_packet", {5'd0, bus.rx_packet}, 8'd1);
    check("out error", {7'd0, bus.rx_error}, 8'd0);

    // reset in the middle of a DATA0 packet
    expect_ev(K_FLUSH, 8'h00);
    send_sync();
    send_byte(8'hC3);
    send_byte(8'h01);
    check("pre-rst active", {7'd0, bus.rx_transfer_active}, 8'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst rx_packet", {5'd0, bus.rx_packet}, 8'd0);
    check("rst active", {7'd0, bus.rx_transfer_active}, 8'd0);
    check("rst error", {7'd0, bus.rx_error}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h02);
    send_byte(8'h03);
    send_eop(12);
    check("tail rx_packet", {5'd0, bus.rx_packet}, 8'd0);

    // normal DATA1 after recovery
    expect_ev(K_FLUSH, 8'h00);
    expect_ev(K_STORE, 8'hAA);
    expect_ev(K_READY, 8'd4);
    send_sync();
    send_byte(8'h4B);
    send_byte(8'hAA);
    send_byte(8'h12);
    send_byte(8'h34);
    send_eop(4);
    check("post-rst rx_packet", {5'd0, bus.rx_packet}, 8'd4);
    check("post-rst error", {7'd0, bus.rx_error}, 8'd0);

    repeat (4) line(1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending events: got %0d left expected 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
